tile_shift_sequencer: RTL and testbench

Fetch-and-shift controller for the tile graphics path. It issues ROM byte requests for each tile column, double-buffers the fetched plane bytes, and loads and shifts one 8-bit parallel-in/serial-out shifter per plane on every pixel clock enable. The output is one PLANES-bit pixel per pixel clock enable. It sits between the shared graphics ROM port and the palette/priority mux, replacing the discrete load/shift-select glue around the 8-bit shifters.

---
 rtl/tile_shift_sequencer_if.sv | 12 +
 rtl/tile_shift_sequencer.sv | 177 +++++++++++++++++
 tb/tb_tile_shift_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_shift_sequencer_if.sv
// ROM fetch port between the tile shift sequencer (master) and the shared graphics ROM (slave).
interface tile_shift_sequencer_if #(
  parameter int ADDR_W = 14
);
  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ack;
  logic [7:0]        rom_data;

  modport master (output rom_req, output rom_addr, input rom_ack, input rom_data);
  modport slave  (input rom_req, input rom_addr, output rom_ack, output rom_data);
endinterface

// File: rtl/tile_shift_sequencer.sv
// Tile fetch-and-shift controller: fetches plane bytes per tile column into a double buffer
// and shifts one 8-bit PISO register per plane on every pixel clock enable.
module tile_shift_sequencer #(
  parameter int PLANES = 2,
  parameter int TILES  = 32,
  parameter int ADDR_W = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pix_ce,
  input  logic                   line_start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic                   hflip,
  tile_shift_sequencer_if.master rom,
  output logic [PLANES-1:0]      pix,
  output logic                   active,
  output logic                   underrun
);
  localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int TW = $clog2(TILES + 1);
  localparam logic [PW-1:0] LAST_PLANE = PW'(PLANES - 1);
  localparam logic [TW-1:0] TILE_CNT   = TW'(TILES);

  // S_START is the forced one-cycle gap that follows every line_start.
  typedef enum logic [2:0] {S_IDLE, S_START, S_REQ, S_GAP, S_FULL, S_DONE} state_e;
  state_e state_q, state_d;

  logic [ADDR_W-1:0] base_q, base_d;
  logic              hflip_q, hflip_d;
  logic [TW-1:0]     tile_q, tile_d;
  logic [PW-1:0]     plane_q, plane_d;
  logic              buf_valid_q, buf_valid_d;
  logic              active_q, active_d;
  logic              underrun_q, underrun_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        fbuf_q [PLANES];
  logic [7:0]        fbuf_d [PLANES];
  logic [7:0]        sh_q   [PLANES];
  logic [7:0]        sh_d   [PLANES];

  logic              ack_hit;
  logic              load_pt;
  logic              consume;
  logic              tiles_left;
  logic [TW-1:0]     tile_inc;
  logic [ADDR_W-1:0] fetch_addr;

  assign ack_hit    = (state_q == S_REQ) && rom.rom_ack;
  assign load_pt    = pix_ce && (active_q ? (cnt_q == 3'd7) : buf_valid_q);
  assign consume    = load_pt && buf_valid_q;
  assign tiles_left = (tile_q < TILE_CNT);
  assign tile_inc   = tile_q + TW'(1);
  assign fetch_addr = base_q + ADDR_W'(tile_q) * ADDR_W'(PLANES) + ADDR_W'(plane_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (line_start) begin
      state_d = S_START;
    end else begin
      unique case (state_q)
        S_START: state_d = S_REQ;
        S_REQ:   if (ack_hit) state_d = S_GAP;
        S_GAP:   state_d = (plane_q == LAST_PLANE) ? S_FULL : S_REQ;
        S_FULL:  if (consume) state_d = (tile_inc < TILE_CNT) ? S_REQ : S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    rom.rom_req  = 1'b0;
    rom.rom_addr = '0;
    if (state_q == S_REQ) begin
      rom.rom_req  = 1'b1;
      rom.rom_addr = fetch_addr;
    end
  end

  always_comb begin
    base_d      = base_q;
    hflip_d     = hflip_q;
    tile_d      = tile_q;
    plane_d     = plane_q;
    buf_valid_d = buf_valid_q;
    active_d    = active_q;
    underrun_d  = underrun_q;
    cnt_d       = cnt_q;
    fbuf_d      = fbuf_q;
    sh_d        = sh_q;
    if (line_start) begin
      base_d      = base_addr;
      hflip_d     = hflip;
      tile_d      = '0;
      plane_d     = '0;
      buf_valid_d = 1'b0;
      active_d    = 1'b0;
      underrun_d  = 1'b0;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        S_REQ:  if (ack_hit) fbuf_d[plane_q] = rom.rom_data;
        S_GAP:  if (plane_q == LAST_PLANE) begin
                  buf_valid_d = 1'b1;
                  plane_d     = '0;
                end else begin
                  plane_d = plane_q + PW'(1);
                end
        S_FULL: if (consume) tile_d = tile_inc;
        default: ;
      endcase

      // A missing tile shows as blank pixels and stays queued, so it lands one slot late.
      if (load_pt) begin
        cnt_d = '0;
        if (buf_valid_q) begin
          sh_d        = fbuf_q;
          buf_valid_d = 1'b0;
          active_d    = 1'b1;
        end else if (tiles_left) begin
          sh_d       = '{default: '0};
          underrun_d = 1'b1;
        end else begin
          active_d = 1'b0;
        end
      end else if (active_q && pix_ce) begin
        cnt_d = cnt_q + 3'd1;
        for (int p = 0; p < PLANES; p++)
          sh_d[p] = hflip_q ? (sh_q[p] >> 1) : (sh_q[p] << 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q      <= '0;
      hflip_q     <= 1'b0;
      tile_q      <= '0;
      plane_q     <= '0;
      buf_valid_q <= 1'b0;
      active_q    <= 1'b0;
      underrun_q  <= 1'b0;
      cnt_q       <= '0;
      sh_q        <= '{default: '0};
    end else begin
      base_q      <= base_d;
      hflip_q     <= hflip_d;
      tile_q      <= tile_d;
      plane_q     <= plane_d;
      buf_valid_q <= buf_valid_d;
      active_q    <= active_d;
      underrun_q  <= underrun_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
    end
  end

  // NOTE: fetch buffer contents are not reset; buf_valid_q alone says whether they mean anything.
  always_ff @(posedge clk) begin
    fbuf_q <= fbuf_d;
  end

  always_comb begin
    pix = '0;
    for (int p = 0; p < PLANES; p++)
      pix[p] = active_q & (hflip_q ? sh_q[p][0] : sh_q[p][7]);
  end

  assign active   = active_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_tile_shift_sequencer.sv
// Scoreboard bench for tile_shift_sequencer: ROM request and pixel streams are checked by
// monitors against queues filled by the directed stimulus.
module tb_tile_shift_sequencer;
  localparam int PLANES = 2;
  localparam int TILES  = 4;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              reset;
  logic              pix_ce;
  logic              line_start;
  logic [ADDR_W-1:0] base_addr;
  logic              hflip;
  logic [PLANES-1:0] pix;
  logic              active;
  logic              underrun;

  tile_shift_sequencer_if #(.ADDR_W(ADDR_W)) rom_bus ();

  tile_shift_sequencer #(.PLANES(PLANES), .TILES(TILES), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_ce     (pix_ce),
    .line_start (line_start),
    .base_addr  (base_addr),
    .hflip      (hflip),
    .rom        (rom_bus.master),
    .pix        (pix),
    .active     (active),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int   total;
  int   bad;
  int   exp_addr [$];
  int   exp_pix  [$];
  bit   pix_chk;
  int   pix_seen;
  int   slow_addr;
  int   slow_wait;
  bit   force_ack;
  bit   gap_pending;
  int   rom_age;
  int   cyc;
  int   n;
  logic [7:0] rom_mem [0:(1<<ADDR_W)-1];

  int vec_a [8] = '{1, 0, 1, 0, 2, 3, 2, 3};
  int vec_b [8] = '{3, 2, 3, 2, 0, 1, 0, 1};

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic flag(input string name, input int act);
    total++;
    bad++;
    $display("FAIL %s: unexpected event, value %0d (0x%0h)", name, act, act);
  endtask

  function automatic int pix_val(input logic [7:0] b0, input logic [7:0] b1, input int i, input bit hf);
    int k;
    k = hf ? i : 7 - i;
    return int'({b1[k], b0[k]});
  endfunction

  task automatic push_tile(input int addr, input bit hf);
    logic [ADDR_W-1:0] a0, a1;
    a0 = ADDR_W'(addr);
    a1 = ADDR_W'(addr + 1);
    for (int i = 0; i < 8; i++) exp_pix.push_back(pix_val(rom_mem[a0], rom_mem[a1], i, hf));
  endtask

  task automatic push_zeros();
    for (int i = 0; i < 8; i++) exp_pix.push_back(0);
  endtask

  task automatic push_line_reqs(input int base);
    for (int t = 0; t < PLANES * TILES; t++) exp_addr.push_back((base + t) % (1 << ADDR_W));
  endtask

  task automatic start_line(input int base, input bit hf);
    @(negedge clk);
    line_start = 1'b1;
    base_addr  = ADDR_W'(base);
    hflip      = hf;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_line(input string name, input int budget);
    int k;
    k = 0;
    while (!active && k < budget) begin @(negedge clk); k++; end
    while (active && k < budget) begin @(negedge clk); k++; end
    if (k >= budget) flag({name, "_timeout"}, k);
  endtask

  // Pixel enable every 4th cycle, updated just after the rising edge.
  initial begin
    cyc    = 0;
    pix_ce = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      pix_ce = (cyc % 4 == 0);
    end
  end

  // ROM slave: zero-wait except for one selectable slow address.
  initial begin
    rom_age          = 0;
    rom_bus.rom_ack  = 1'b0;
    rom_bus.rom_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (force_ack) begin
        rom_bus.rom_ack  = 1'b1;
        rom_bus.rom_data = 8'hFF;
        rom_age          = 0;
      end else if (!rom_bus.rom_req) begin
        rom_bus.rom_ack = 1'b0;
        rom_age         = 0;
      end else begin
        rom_bus.rom_data = rom_mem[rom_bus.rom_addr];
        rom_bus.rom_ack  = (rom_age >= ((int'(rom_bus.rom_addr) == slow_addr) ? slow_wait : 0));
        rom_age          = rom_bus.rom_ack ? 0 : rom_age + 1;
      end
    end
  end

  // Request monitor: each completed transfer pops an expected address; a low cycle must follow.
  initial begin
    gap_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (gap_pending) begin
        check("gap_after_ack", int'(rom_bus.rom_req), 0);
        gap_pending = 1'b0;
      end
      if (rom_bus.rom_req && rom_bus.rom_ack) begin
        if (exp_addr.size() == 0) flag("req_unexpected", int'(rom_bus.rom_addr));
        else check("req_addr", int'(rom_bus.rom_addr), exp_addr.pop_front());
        gap_pending = 1'b1;
      end
    end
  end

  // Pixel monitor: each pix_ce cycle with active high consumes one displayed pixel.
  initial begin
    forever begin
      @(negedge clk);
      if (pix_chk && pix_ce && active) begin
        pix_seen++;
        if (exp_pix.size() == 0) flag("pix_extra", int'(pix));
        else check($sformatf("pix_%0d", pix_seen - 1), int'(pix), exp_pix.pop_front());
      end
    end
  end

  initial begin
    total = 0; bad = 0; pix_seen = 0; pix_chk = 1'b0;
    slow_addr = -1; slow_wait = 0; force_ack = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = 8'(i * 29 + 7);
    rom_mem[14'h100] = 8'hA5;
    rom_mem[14'h101] = 8'h0F;
    reset = 1'b1; line_start = 1'b0; base_addr = '0; hflip = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_rom_req",  int'(rom_bus.rom_req),  0);
    check("rst_rom_addr", int'(rom_bus.rom_addr), 0);
    check("rst_pix",      int'(pix),              0);
    check("rst_active",   int'(active),           0);
    check("rst_underrun", int'(underrun),         0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_no_req", int'(rom_bus.rom_req), 0);

    // Normal line, hflip=0.
    push_line_reqs(14'h100);
    foreach (vec_a[i]) exp_pix.push_back(vec_a[i]);
    for (int t = 1; t < TILES; t++) push_tile(14'h100 + 2 * t, 1'b0);
    pix_seen = 0; pix_chk = 1'b1;
    start_line(14'h100, 1'b0);
    wait_line("line_a", 1000);
    check("a_pix_count", pix_seen, 32);
    check("a_req_left",  exp_addr.size(), 0);
    check("a_pix_left",  exp_pix.size(), 0);
    check("a_underrun",  int'(underrun), 0);
    check("a_pix_idle",  int'(pix), 0);

    // Same data, hflip=1.
    push_line_reqs(14'h100);
    foreach (vec_b[i]) exp_pix.push_back(vec_b[i]);
    for (int t = 1; t < TILES; t++) push_tile(14'h100 + 2 * t, 1'b1);
    pix_seen = 0;
    start_line(14'h100, 1'b1);
    wait_line("line_b", 1000);
    check("b_pix_count", pix_seen, 32);
    check("b_pix_left",  exp_pix.size(), 0);

    // Tile 1 plane 0 acked 40 cycles late: one blank tile slot, then tile 1 onward.
    slow_addr = 14'h102; slow_wait = 40;
    push_line_reqs(14'h100);
    foreach (vec_a[i]) exp_pix.push_back(vec_a[i]);
    push_zeros();
    for (int t = 1; t < TILES; t++) push_tile(14'h100 + 2 * t, 1'b0);
    pix_seen = 0;
    start_line(14'h100, 1'b0);
    wait_line("line_c", 2000);
    check("c_pix_count", pix_seen, 40);
    check("c_underrun",  int'(underrun), 1);
    check("c_req_left",  exp_addr.size(), 0);
    check("c_pix_left",  exp_pix.size(), 0);

    // Abort a stalled request at 0x102; the ack in the following cycle must be ignored.
    pix_chk = 1'b0; slow_wait = 1000;
    exp_addr.push_back(14'h100);
    exp_addr.push_back(14'h101);
    start_line(14'h100, 1'b0);
    check("underrun_cleared", int'(underrun), 0);
    n = 0;
    while (!(rom_bus.rom_req && rom_bus.rom_addr == 14'h102) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) flag("abort_wait_timeout", n);
    check("abort_req_left", exp_addr.size(), 0);
    push_line_reqs(14'h200);
    exp_pix.delete();
    for (int t = 0; t < TILES; t++) push_tile(14'h200 + 2 * t, 1'b0);
    line_start = 1'b1; base_addr = 14'h200; force_ack = 1'b1;
    @(negedge clk);
    line_start = 1'b0; force_ack = 1'b0;
    check("abort_req_low", int'(rom_bus.rom_req), 0);
    check("abort_active",  int'(active), 0);
    pix_seen = 0; pix_chk = 1'b1;
    wait_line("line_abort", 1000);
    check("abort_pix_count", pix_seen, 32);
    check("abort_req_done",  exp_addr.size(), 0);
    check("abort_pix_left",  exp_pix.size(), 0);

    // Address wrap, then reset mid-line while underrun is set.
    slow_addr = 14'h0001; slow_wait = 40;
    exp_addr.push_back(14'h3FFF);
    exp_addr.push_back(14'h0000);
    push_tile(14'h3FFF, 1'b0);
    push_zeros();
    pix_seen = 0;
    start_line(14'h3FFF, 1'b0);
    n = 0;
    while (!underrun && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) flag("wrap_underrun_timeout", n);
    pix_chk = 1'b0;
    check("wrap_req_left", exp_addr.size(), 0);
    check("wrap_pix_seen", int'(pix_seen >= 8), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_rom_req",  int'(rom_bus.rom_req), 0);
    check("mid_rst_pix",      int'(pix), 0);
    check("mid_rst_active",   int'(active), 0);
    check("mid_rst_underrun", int'(underrun), 0);
    reset = 1'b0; slow_addr = -1;
    exp_pix.delete();
    repeat (60) @(negedge clk);
    check("post_rst_idle", int'(rom_bus.rom_req), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
